b2b_link_tx_framer: RTL and testbench
=====================================

B2B_LINK_TX_FRAMER -- requirements
Module: b2b_link_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 65: event word width; bit DATA_WIDTH-1 is the metadata flag.
REQ-002 Parameter FIFO_DEPTH_BITS, default 6: buffer depth is 2**FIFO_DEPTH_BITS words.
REQ-003 Parameter AF_MARGIN, default 8: almost-full asserts at occupancy >= depth - AF_MARGIN.
REQ-004 Parameter BOARD_ID, default 0: destination board index, driven on link_board_id.
REQ-005 b2b_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 b2b_rst  in  1  reset, synchronous, active-high.
REQ-007 in_event  in  DATA_WIDTH  event word from the board-to-board switch, one output-board lane.
REQ-008 in_wren  in  1  in_event valid this cycle.
REQ-009 in_almost_full  out  1  backpressure to the switch lane.
REQ-010 link_data  out  DATA_WIDTH  word toward the inter-board link.
REQ-011 link_valid / link_sop / link_eop  out  1 each  word valid, first word of event, last word of event.
REQ-012 link_ready  in  1  link accepts link_data when high with link_valid.
REQ-013 link_board_id  out  8  constant BOARD_ID.
REQ-014 overflow  out  1  sticky: a write was dropped.
REQ-015 drop_count / malformed_count / event_count  out  16 each  saturating counters.

Function
REQ-016 Framing: event = header (meta=1), zero or more data words (meta=0), footer (meta=1); write-side toggle marks the first meta word header and the next footer.
REQ-017 Buffer is first-word-fall-through: a word written in cycle N is visible at the head in cycle N+1.
REQ-018 Write when full: word dropped, overflow set, drop_count +1, framing toggle still advances on meta words.
REQ-019 complete_events counter: +1 the cycle after a footer is written, -1 the cycle after a footer is popped; simultaneous inc/dec leaves it unchanged.
REQ-020 FSM states IDLE, SEND, FLUSH.
REQ-021 IDLE, head meta=0: pop it, malformed_count +1, stay IDLE, link_valid=0.
REQ-022 IDLE, head meta=1 and (complete_events>0 or buffer full): go to SEND next cycle.
REQ-023 SEND: link_valid=1, link_data=head; link_sop=1 on the header word only, link_eop=1 on the footer word only.
REQ-024 SEND: pop only when link_valid && link_ready; link_data/flags hold stable while link_ready=0.
REQ-025 SEND, footer accepted: event_count +1, go to IDLE (one-cycle bubble minimum between events).
REQ-026 SEND entered via buffer-full (no complete event): cut-through; if the buffer empties before the footer, link_valid deasserts and SEND waits for data.
REQ-027 SEND, a header arrives at head before a footer: go to FLUSH, malformed_count +1, no pop.
REQ-028 FLUSH: drive one footer word (meta=1, payload zero, link_eop=1); on acceptance go to IDLE without popping.
REQ-029 in_almost_full is registered from occupancy, one-cycle latency.
REQ-030 Occupancy arithmetic is FIFO_DEPTH_BITS+1 bits wide; simultaneous read and write when full or empty behave correctly (write to full with pop in the same cycle is accepted).
REQ-031 Counters saturate at 16'hFFFF.

Reset
REQ-032 b2b_rst=1 at a clock edge: buffer empty, complete_events=0, write toggle cleared to expect a header, FSM=IDLE.
REQ-033 During and after reset: link_valid/sop/eop=0, link_data=0, in_almost_full=0, overflow=0, all counters 0.
REQ-034 Reset mid-event discards the partial event; no footer is emitted for it.

Verification
REQ-035 Write header, 3 data, footer back-to-back from cycle 0, link_ready=1 -> link_valid first at cycle 7, 5 words with sop on word 1 and eop on word 5, event_count=1.
REQ-036 Same event with link_ready toggled 1,0,1,0,... -> identical word sequence, each word held stable while stalled.
REQ-037 Depth 64, AF_MARGIN 8, link_ready=0, 70 writes -> in_almost_full high the cycle after the 56th write, drop_count=6, overflow=1.
REQ-038 Write a data word, then a valid event -> malformed_count=1, only the valid event appears on the link.
REQ-039 Event of 80 words with depth 64 -> cut-through SEND on full; all 80 words delivered in order, sop/eop correct, no drops.
REQ-040 b2b_rst asserted mid-SEND for one cycle -> next cycle all outputs zero, a following event is delivered intact.

Source files
------------

// File: rtl/b2b_link_tx_framer.sv
// Board-to-board link transmit framer: buffers one switch lane in a first-word-fall-through
// FIFO and forwards header/data/footer events to the inter-board link with sop/eop framing.
module b2b_link_tx_framer #(
  parameter int DATA_WIDTH      = 65,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int AF_MARGIN       = 8,
  parameter int BOARD_ID        = 0
) (
  input  logic                  b2b_clk,
  input  logic                  b2b_rst,
  input  logic [DATA_WIDTH-1:0] in_event,
  input  logic                  in_wren,
  output logic                  in_almost_full,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic                  link_valid,
  output logic                  link_sop,
  output logic                  link_eop,
  input  logic                  link_ready,
  output logic [7:0]            link_board_id,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [15:0]           malformed_count,
  output logic [15:0]           event_count
);

  localparam int AW = FIFO_DEPTH_BITS;
  localparam logic [AW:0] ZERO_C     = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_C      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] TWO_C      = ONE_C + ONE_C;
  localparam logic [AW:0] DEPTH_C    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_LEVEL_C = DEPTH_C - (AW+1)'(AF_MARGIN);
  localparam logic [DATA_WIDTH-1:0] FLUSH_WORD_C = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FLUSH = 2'd2} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Each entry carries the word plus a footer tag taken from the write-side toggle.
  logic [DATA_WIDTH:0] mem_r [2**AW];
  logic [AW:0]         wr_ptr_r, rd_ptr_r, complete_r;
  logic [AW:0]         occ_s, occ_next_s, rd_next_s;
  logic [DATA_WIDTH:0] head_s, next_s;
  logic                wr_toggle_r, full_s, pop_s, wr_accept_s, footer_wr_s, footer_pop_s;
  logic                head_meta_s, head_footer_s, head_header_s, next_header_s;
  logic                almost_full_r, overflow_r, sop_pending_r;
  logic                link_valid_r, link_sop_r, link_eop_r;
  logic [DATA_WIDTH-1:0] link_data_r;
  logic [15:0]         drop_count_r, malformed_count_r, event_count_r;
  state_t              state_r;

  // Buffer status, head decode and pop/accept decisions.
  always_comb begin
    occ_s         = wr_ptr_r - rd_ptr_r;
    full_s        = (occ_s == DEPTH_C);
    rd_next_s     = rd_ptr_r + ONE_C;
    head_s        = mem_r[rd_ptr_r[AW-1:0]];
    next_s        = mem_r[rd_next_s[AW-1:0]];
    head_meta_s   = head_s[DATA_WIDTH-1];
    head_footer_s = head_s[DATA_WIDTH];
    head_header_s = head_meta_s & ~head_footer_s;
    next_header_s = next_s[DATA_WIDTH-1] & ~next_s[DATA_WIDTH];
    case (state_r)
      IDLE:    pop_s = (occ_s != ZERO_C) && (!head_meta_s || head_footer_s);
      SEND:    pop_s = link_valid_r && link_ready;
      default: pop_s = 1'b0;
    endcase
    wr_accept_s  = in_wren && (!full_s || pop_s);
    footer_wr_s  = wr_accept_s && in_event[DATA_WIDTH-1] && wr_toggle_r;
    footer_pop_s = pop_s && head_footer_s;
    occ_next_s   = occ_s + (AW+1)'(wr_accept_s) - (AW+1)'(pop_s);
  end

  // Buffer storage; contents need no reset because the pointers define validity.
  always_ff @(posedge b2b_clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {wr_toggle_r & in_event[DATA_WIDTH-1], in_event};
    end
  end

  // Write side: pointers, framing toggle, complete-event count, drops and backpressure.
  always_ff @(posedge b2b_clk) begin
    if (b2b_rst) begin
      wr_ptr_r      <= ZERO_C;
      rd_ptr_r      <= ZERO_C;
      complete_r    <= ZERO_C;
      wr_toggle_r   <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      drop_count_r  <= 16'd0;
    end else begin
      if (wr_accept_s) wr_ptr_r <= wr_ptr_r + ONE_C;
      if (pop_s) rd_ptr_r <= rd_next_s;
      if (in_wren && in_event[DATA_WIDTH-1]) wr_toggle_r <= ~wr_toggle_r;
      if (in_wren && !wr_accept_s) begin
        overflow_r   <= 1'b1;
        drop_count_r <= sat_inc(drop_count_r);
      end
      case ({footer_wr_s, footer_pop_s})
        2'b10:   complete_r <= complete_r + ONE_C;
        2'b01:   complete_r <= complete_r - ONE_C;
        default: complete_r <= complete_r;
      endcase
      almost_full_r <= (occ_next_s >= AF_LEVEL_C);
    end
  end

  // Link-side FSM; the output registers always mirror the buffer head while SEND is valid.
  always_ff @(posedge b2b_clk) begin
    if (b2b_rst) begin
      state_r           <= IDLE;
      sop_pending_r     <= 1'b0;
      link_valid_r      <= 1'b0;
      link_sop_r        <= 1'b0;
      link_eop_r        <= 1'b0;
      link_data_r       <= {DATA_WIDTH{1'b0}};
      malformed_count_r <= 16'd0;
      event_count_r     <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            malformed_count_r <= sat_inc(malformed_count_r);
          end else if ((occ_s != ZERO_C) && ((complete_r != ZERO_C) || full_s)) begin
            state_r       <= SEND;
            sop_pending_r <= 1'b1;
          end
        end
        SEND: begin
          if (link_valid_r) begin
            if (link_ready) begin
              if (link_eop_r) begin
                event_count_r <= sat_inc(event_count_r);
                state_r       <= IDLE;
                link_valid_r  <= 1'b0;
                link_sop_r    <= 1'b0;
                link_eop_r    <= 1'b0;
                link_data_r   <= {DATA_WIDTH{1'b0}};
              end else if (occ_s >= TWO_C) begin
                link_sop_r <= 1'b0;
                if (next_header_s) begin
                  state_r           <= FLUSH;
                  malformed_count_r <= sat_inc(malformed_count_r);
                  link_eop_r        <= 1'b1;
                  link_data_r       <= FLUSH_WORD_C;
                end else begin
                  link_eop_r  <= next_s[DATA_WIDTH];
                  link_data_r <= next_s[DATA_WIDTH-1:0];
                end
              end else begin
                // Cut-through ran dry: wait for the next word to land in the buffer.
                link_valid_r <= 1'b0;
                link_sop_r   <= 1'b0;
                link_eop_r   <= 1'b0;
                link_data_r  <= {DATA_WIDTH{1'b0}};
              end
            end
          end else if (occ_s != ZERO_C) begin
            link_valid_r <= 1'b1;
            if (sop_pending_r) begin
              sop_pending_r <= 1'b0;
              link_sop_r    <= 1'b1;
              link_eop_r    <= 1'b0;
              link_data_r   <= head_s[DATA_WIDTH-1:0];
            end else if (head_header_s) begin
              state_r           <= FLUSH;
              malformed_count_r <= sat_inc(malformed_count_r);
              link_sop_r        <= 1'b0;
              link_eop_r        <= 1'b1;
              link_data_r       <= FLUSH_WORD_C;
            end else begin
              link_sop_r  <= 1'b0;
              link_eop_r  <= head_footer_s;
              link_data_r <= head_s[DATA_WIDTH-1:0];
            end
          end
        end
        FLUSH: begin
          if (link_ready) begin
            state_r      <= IDLE;
            link_valid_r <= 1'b0;
            link_eop_r   <= 1'b0;
            link_data_r  <= {DATA_WIDTH{1'b0}};
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_almost_full  = almost_full_r;
  assign link_data       = link_data_r;
  assign link_valid      = link_valid_r;
  assign link_sop        = link_sop_r;
  assign link_eop        = link_eop_r;
  assign link_board_id   = 8'(BOARD_ID);
  assign overflow        = overflow_r;
  assign drop_count      = drop_count_r;
  assign malformed_count = malformed_count_r;
  assign event_count     = event_count_r;

endmodule

// File: tb/tb_b2b_link_tx_framer.sv
// Directed bench for b2b_link_tx_framer: framing latency, stalls, backpressure, malformed
// input, cut-through on full and reset mid-event.
module tb_b2b_link_tx_framer;
  localparam int DW = 65;

  logic          clk = 1'b0;
  logic          b2b_rst = 1'b1;
  logic [DW-1:0] in_event = '0;
  logic          in_wren = 1'b0;
  logic          in_almost_full;
  logic [DW-1:0] link_data;
  logic          link_valid, link_sop, link_eop;
  logic          link_ready = 1'b0;
  logic [7:0]    link_board_id;
  logic          overflow;
  logic [15:0]   drop_count, malformed_count, event_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] ev_q[$];
  logic [DW+1:0] prev_word = '0;
  logic          prev_stall = 1'b0;
  logic          prev_rst = 1'b1;

  always #5 clk = ~clk;

  b2b_link_tx_framer #(.BOARD_ID(42)) dut (
    .b2b_clk(clk), .b2b_rst(b2b_rst), .in_event(in_event), .in_wren(in_wren),
    .in_almost_full(in_almost_full), .link_data(link_data), .link_valid(link_valid),
    .link_sop(link_sop), .link_eop(link_eop), .link_ready(link_ready),
    .link_board_id(link_board_id), .overflow(overflow), .drop_count(drop_count),
    .malformed_count(malformed_count), .event_count(event_count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Capture accepted link words and require stalled words to stay put.
  always @(negedge clk) begin
    if (prev_stall && !prev_rst)
      check_eq("stall_hold", {link_valid, link_sop, link_eop, link_data}, {1'b1, prev_word});
    if (link_valid && link_ready) got_q.push_back({link_sop, link_eop, link_data});
    prev_stall = link_valid && !link_ready;
    prev_word  = {link_sop, link_eop, link_data};
    prev_rst   = b2b_rst;
  end

  task automatic build_event(input logic [15:0] id, input int n_data);
    logic s, e;
    ev_q.delete();
    ev_q.push_back({1'b1, 16'hBEEF, id, 32'h0000_0000});
    for (int i = 0; i < n_data; i++) ev_q.push_back({1'b0, 16'hDA7A, id, 32'(i)});
    ev_q.push_back({1'b1, 16'hF00F, id, 32'hFFFF_FFFF});
    for (int i = 0; i < ev_q.size(); i++) begin
      s = (i == 0);
      e = (i == ev_q.size() - 1);
      exp_q.push_back({s, e, ev_q[i]});
    end
  endtask

  task automatic write_range(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      in_event = ev_q[i];
      in_wren  = 1'b1;
      tick();
    end
    in_wren = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 128'(link_valid), 128'(0));
    check_eq({tag, "_sop"},   128'(link_sop),   128'(0));
    check_eq({tag, "_eop"},   128'(link_eop),   128'(0));
    check_eq({tag, "_data"},  128'(link_data),  128'(0));
    check_eq({tag, "_af"},    128'(in_almost_full), 128'(0));
    check_eq({tag, "_ovf"},   128'(overflow),   128'(0));
    check_eq({tag, "_drop"},  128'(drop_count), 128'(0));
    check_eq({tag, "_malf"},  128'(malformed_count), 128'(0));
    check_eq({tag, "_evt"},   128'(event_count), 128'(0));
  endtask

  initial begin
    repeat (2) tick();
    check_zero("rst");
    check_eq("board_id", 128'(link_board_id), 128'(42));
    b2b_rst = 1'b0;
    tick();

    // Back-to-back event, link always ready: first valid at cycle 7.
    link_ready = 1'b1;
    build_event(16'h0001, 3);
    cyc = 0;
    write_range(0, 5);
    while (!link_valid && cyc < 40) tick();
    check_eq("t1_first_valid_cycle", 128'(cyc), 128'(7));
    drain(40);
    compare_stream("t1");
    check_eq("t1_event_count", 128'(event_count), 128'(1));

    // Same event shape with link_ready toggling every cycle.
    build_event(16'h0002, 3);
    write_range(0, 5);
    for (int n = 0; n < 80 && got_q.size() < exp_q.size(); n++) begin
      link_ready = ~link_ready;
      tick();
    end
    link_ready = 1'b1;
    drain(20);
    compare_stream("t2");
    check_eq("t2_event_count", 128'(event_count), 128'(2));

    // Stray data word ahead of a valid event.
    ev_q.delete();
    ev_q.push_back({1'b0, 64'h0BAD_0BAD_0BAD_0BAD});
    write_range(0, 1);
    build_event(16'h0003, 2);
    write_range(0, 4);
    drain(40);
    compare_stream("t3");
    check_eq("t3_malformed", 128'(malformed_count), 128'(1));
    check_eq("t3_event_count", 128'(event_count), 128'(3));

    // 70 writes into a 64-deep buffer with the link stalled.
    link_ready = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      in_event = (i == 1) ? {1'b1, 64'hBEEF_0004_0000_0000} : {1'b0, 64'(i)};
      in_wren  = 1'b1;
      tick();
      if (i == 55) check_eq("t4_af_after_55", 128'(in_almost_full), 128'(0));
      if (i == 56) check_eq("t4_af_after_56", 128'(in_almost_full), 128'(1));
    end
    in_wren = 1'b0;
    tick();
    check_eq("t4_drop_count", 128'(drop_count), 128'(6));
    check_eq("t4_overflow", 128'(overflow), 128'(1));
    check_eq("t4_cut_through_sop", 128'({link_valid, link_sop}), 128'(3));
    check_eq("t4_nothing_sent", 128'(got_q.size()), 128'(0));
    b2b_rst = 1'b1;
    tick();
    b2b_rst = 1'b0;
    check_zero("t4_rst");
    got_q.delete();

    // 80-word event: cut-through once the buffer fills, then one write per accepted word.
    link_ready = 1'b1;
    build_event(16'h0005, 78);
    write_range(0, 64);
    for (int n = 0; n < 20 && !link_valid; n++) tick();
    write_range(64, 16);
    drain(200);
    compare_stream("t5");
    check_eq("t5_drop_count", 128'(drop_count), 128'(0));
    check_eq("t5_overflow", 128'(overflow), 128'(0));
    check_eq("t5_event_count", 128'(event_count), 128'(1));

    // Reset mid-SEND, then a fresh event must arrive intact.
    build_event(16'h0006, 6);
    write_range(0, 8);
    for (int n = 0; n < 40 && got_q.size() < 3; n++) tick();
    check_eq("t6_mid_send", 128'(link_valid), 128'(1));
    b2b_rst = 1'b1;
    tick();
    b2b_rst = 1'b0;
    check_zero("t6_rst");
    got_q.delete();
    exp_q.delete();
    build_event(16'h0007, 2);
    write_range(0, 4);
    drain(40);
    compare_stream("t6");
    check_eq("t6_event_count", 128'(event_count), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
